// File: rtl/axis_bram_capture.sv
// AXI-Stream sink capturing one tlast-terminated frame into BRAM; optional tstrb check via AXIS_CAPTURE_STRB_CHECK_EN.
// Latency: done/frame_len one cycle after the tlast beat; rd_data one cycle after rd_addr (read-first).
// Backpressure: tready is a pure state decode, high only in CAPTURE/DRAIN; overflow beats are drained, not stalled.
module axis_bram_capture #(
    parameter int DATA_WIDTH = 48,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_areset,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                      s00_axis_tlast,
    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic                      arm,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [ADDR_WIDTH:0]       frame_len,
    output logic                      strb_err,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_addr;
    logic                  beat;
    logic                  at_last;
    logic                  wr_en;

    assign s00_axis_tready = (state == CAPTURE) || (state == DRAIN);
    assign busy            = s00_axis_tready;
    assign done            = (state == DONE);
    assign beat            = s00_axis_tvalid && s00_axis_tready;
    // wr_addr never exceeds DEPTH-1 while in CAPTURE, so the low bits suffice
    assign at_last         = (wr_addr[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
    assign wr_en           = (state == CAPTURE) && beat;

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (beat && s00_axis_tlast) state_nxt = DONE;
                else if (beat && at_last)   state_nxt = DRAIN;
            end
            DRAIN: begin
                if (beat && s00_axis_tlast) state_nxt = DONE;
            end
            DONE: begin
                if (arm) state_nxt = CAPTURE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            wr_addr   <= '0;
            overflow  <= 1'b0;
            frame_len <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        wr_addr  <= '0;
                        overflow <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (beat) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (s00_axis_tlast) frame_len <= wr_addr + 1'b1;
                        else if (at_last)   overflow  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (beat && s00_axis_tlast) frame_len <= FULL_LEN;
                end
                default: ;
            endcase
        end
    end

`ifdef AXIS_CAPTURE_STRB_CHECK_EN
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            strb_err <= 1'b0;
        end else if ((state == IDLE || state == DONE) && arm) begin
            strb_err <= 1'b0;
        end else if (beat && (s00_axis_tstrb != {(DATA_WIDTH/8){1'b1}})) begin
            strb_err <= 1'b1;
        end
    end
`else
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;
    assign strb_err     = 1'b0;
`endif

    // BRAM array carries no reset so it maps onto block RAM
    always_ff @(posedge s00_axis_aclk) begin
        if (wr_en) mem[wr_addr[ADDR_WIDTH-1:0]] <= s00_axis_tdata;
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_axis_bram_capture.sv
// Directed bench for axis_bram_capture with a 16-word BRAM (ADDR_WIDTH=4).
module tb_axis_bram_capture;

    localparam int DW = 48;
    localparam int AW = 4;
`ifdef AXIS_CAPTURE_STRB_CHECK_EN
    localparam logic STRB_EXP = 1'b1;
`else
    localparam logic STRB_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   tdata = '0;
    logic [DW/8-1:0] tstrb = '1;
    logic            tlast = 1'b0;
    logic            tvalid = 1'b0;
    logic            tready;
    logic            arm = 1'b0;
    logic            busy, done, overflow, strb_err;
    logic [AW:0]     frame_len;
    logic [AW-1:0]   rd_addr = '0;
    logic [DW-1:0]   rd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_bram_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tlast  (tlast),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .arm             (arm),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .frame_len       (frame_len),
        .strb_err        (strb_err),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [DW/8-1:0] strb);
        int n;
        n = 0;
        tdata = d; tlast = last; tstrb = strb; tvalid = 1'b1;
        while (!tready && n < 50) begin
            step();
            n++;
        end
        if (!tready) begin
            tests++; fails++;
            $display("FAIL beat_timeout: tready=%0b after %0d cycles, want 1 (data %0h)", tready, n, d);
        end else begin
            step();
        end
        tvalid = 1'b0; tlast = 1'b0; tstrb = '1;
    endtask

    task automatic test_reset();
        step(); step();
        tests++; if (tready !== 1'b0)   begin fails++; $display("FAIL rst_tready: got %0b want 0", tready); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL rst_done: got %0b want 0", done); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
        tests++; if (frame_len !== 5'd0) begin fails++; $display("FAIL rst_frame_len: got %0d want 0", frame_len); end
        tests++; if (strb_err !== 1'b0) begin fails++; $display("FAIL rst_strb_err: got %0b want 0", strb_err); end
        tests++; if (rd_data !== 48'h0) begin fails++; $display("FAIL rst_rd_data: got %0h want 0", rd_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_frame();
        pulse_arm();
        tests++; if (busy !== 1'b1 || tready !== 1'b1) begin fails++; $display("FAIL basic_armed: busy=%0b tready=%0b want 1 1", busy, tready); end
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_early: got %0b want 0", done); end
            end
            send_beat(48'(i), (i == 15), '1);
        end
        tests++; if (done !== 1'b1)      begin fails++; $display("FAIL basic_done: got %0b want 1", done); end
        tests++; if (tready !== 1'b0)    begin fails++; $display("FAIL basic_tready_drop: got %0b want 0", tready); end
        tests++; if (frame_len !== 5'd16) begin fails++; $display("FAIL basic_frame_len: got %0d want 16", frame_len); end
        tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL basic_overflow: got %0b want 0", overflow); end
        rd_addr = 4'd5;
        step();
        tests++; if (rd_data !== 48'h000000000005) begin fails++; $display("FAIL basic_rd5: got %0h want 5", rd_data); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            step();
            tests++; if (rd_data !== 48'(i)) begin fails++; $display("FAIL basic_mem[%0d]: got %0h want %0h", i, rd_data, i); end
        end
    endtask

    task automatic test_gapped_valid();
        pulse_arm();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL gap_arm_clears_done: got %0b want 0", done); end
        for (int i = 0; i < 8; i++) begin
            send_beat(48'h100 + 48'(i), (i == 7), '1);
            if (i < 7) step();
        end
        tests++; if (done !== 1'b1)      begin fails++; $display("FAIL gap_done: got %0b want 1", done); end
        tests++; if (frame_len !== 5'd8) begin fails++; $display("FAIL gap_frame_len: got %0d want 8", frame_len); end
        for (int i = 0; i < 9; i++) begin
            rd_addr = 4'(i);
            step();
            // word 8 must still hold the previous frame's sample
            tests++; if (rd_data !== ((i < 8) ? (48'h100 + 48'(i)) : 48'h8)) begin
                fails++; $display("FAIL gap_mem[%0d]: got %0h want %0h", i, rd_data, (i < 8) ? (48'h100 + 48'(i)) : 48'h8);
            end
        end
    endtask

    task automatic test_overflow();
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            send_beat(48'h200 + 48'(i), (i == 19), '1);
            if (i == 15) begin
                tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
                tests++; if (tready !== 1'b1)   begin fails++; $display("FAIL ovf_drain_tready: got %0b want 1", tready); end
            end
            if (i == 16) begin
                pulse_arm();
                tests++; if (overflow !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL ovf_arm_ignored: overflow=%0b busy=%0b want 1 1", overflow, busy); end
            end
        end
        tests++; if (done !== 1'b1)       begin fails++; $display("FAIL ovf_done: got %0b want 1", done); end
        tests++; if (overflow !== 1'b1)   begin fails++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        tests++; if (frame_len !== 5'd16) begin fails++; $display("FAIL ovf_frame_len: got %0d want 16", frame_len); end
        rd_addr = 4'd15;
        step();
        tests++; if (rd_data !== 48'h20F) begin fails++; $display("FAIL ovf_mem15: got %0h want 20f", rd_data); end
        rd_addr = 4'd0;
        step();
        tests++; if (rd_data !== 48'h200) begin fails++; $display("FAIL ovf_mem0_nowrap: got %0h want 200", rd_data); end
    endtask

    task automatic test_exact_depth();
        pulse_arm();
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL exact_arm_clears_ovf: got %0b want 0", overflow); end
        for (int i = 0; i < 16; i++) send_beat(48'h300 + 48'(i), (i == 15), '1);
        tests++; if (done !== 1'b1)       begin fails++; $display("FAIL exact_done: got %0b want 1", done); end
        tests++; if (overflow !== 1'b0)   begin fails++; $display("FAIL exact_overflow: got %0b want 0", overflow); end
        tests++; if (frame_len !== 5'd16) begin fails++; $display("FAIL exact_frame_len: got %0d want 16", frame_len); end
        rd_addr = 4'd15;
        step();
        tests++; if (rd_data !== 48'h30F) begin fails++; $display("FAIL exact_mem15: got %0h want 30f", rd_data); end
    endtask

    task automatic test_reset_midframe();
        pulse_arm();
        for (int i = 0; i < 3; i++) send_beat(48'h350 + 48'(i), 1'b0, '1);
        tvalid = 1'b1; tdata = 48'h353;
        #2 rst = 1'b1;
        #1;
        tests++; if (tready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_async: tready=%0b busy=%0b want 0 0", tready, busy); end
        tests++; if (frame_len !== 5'd0) begin fails++; $display("FAIL midrst_frame_len: got %0d want 0", frame_len); end
        tvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
        pulse_arm();
        send_beat(48'h400, 1'b0, '1);
        send_beat(48'h401, 1'b1, '1);
        tests++; if (done !== 1'b1)      begin fails++; $display("FAIL midrst_done: got %0b want 1", done); end
        tests++; if (frame_len !== 5'd2) begin fails++; $display("FAIL midrst_frame_len2: got %0d want 2", frame_len); end
        rd_addr = 4'd1;
        step();
        tests++; if (rd_data !== 48'h401) begin fails++; $display("FAIL midrst_mem1: got %0h want 401", rd_data); end
    endtask

    task automatic test_arm_with_tlast();
        pulse_arm();
        send_beat(48'h500, 1'b0, '1);
        arm = 1'b1;
        send_beat(48'h501, 1'b1, '1);
        arm = 1'b0;
        tests++; if (done !== 1'b1 || tready !== 1'b0) begin fails++; $display("FAIL armlast_done: done=%0b tready=%0b want 1 0", done, tready); end
        step();
        tests++; if (done !== 1'b1)      begin fails++; $display("FAIL armlast_hold: got %0b want 1", done); end
        tests++; if (frame_len !== 5'd2) begin fails++; $display("FAIL armlast_frame_len: got %0d want 2", frame_len); end
    endtask

    task automatic test_strb();
        pulse_arm();
        send_beat(48'h600, 1'b0, 6'h3F);
        tests++; if (strb_err !== 1'b0) begin fails++; $display("FAIL strb_full: got %0b want 0", strb_err); end
        send_beat(48'h601, 1'b1, 6'h0F);
        tests++; if (strb_err !== STRB_EXP) begin fails++; $display("FAIL strb_partial: got %0b want %0b", strb_err, STRB_EXP); end
        tests++; if (frame_len !== 5'd2)    begin fails++; $display("FAIL strb_frame_len: got %0d want 2", frame_len); end
        rd_addr = 4'd1;
        step();
        tests++; if (rd_data !== 48'h601) begin fails++; $display("FAIL strb_full_word: got %0h want 601", rd_data); end
        tests++; if (strb_err !== STRB_EXP) begin fails++; $display("FAIL strb_sticky: got %0b want %0b", strb_err, STRB_EXP); end
        pulse_arm();
        tests++; if (strb_err !== 1'b0) begin fails++; $display("FAIL strb_arm_clear: got %0b want 0", strb_err); end
        send_beat(48'h602, 1'b1, '1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gapped_valid();
        test_overflow();
        test_exact_depth();
        test_reset_midframe();
        test_arm_with_tlast();
        test_strb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
